// File: rtl/uart_pkg.sv
// Shared constants and FSM encodings for the UART receive path and its
// companion baud_rate_gen.
package uart_pkg;

  // System clock and line rate of the target build.
  localparam int CLK       = 50_000_000;
  localparam int BAUD_RATE = 230_400;

  // Oversampling factor: s_tick runs at NUM_TICKS times the baud rate.
  localparam int NUM_TICKS = 16;

  // baud_rate_gen divider: 50 MHz / (230400 * 16) = 13 (truncated).
  localparam int N_CONT = CLK / (BAUD_RATE * NUM_TICKS);

  // Frame format defaults: 8 data bits, one stop bit (16 ticks).
  localparam int DEF_N_DATA_BITS = 8;
  localparam int DEF_SB_TICK     = NUM_TICKS;

  // Receiver FSM encodings.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t STOP  = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input. Resets to 1 so that an
// idle-high serial line does not look like a start bit while leaving reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; q is safe to use two clocks after d changes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled. Detects the start bit, samples each data
// bit in its middle, checks the stop bit and presents the received word.
//
// Output strobe: rx_done_tick is high for exactly one clock per completed
// frame; dout and frame_error change on that same clock and then hold until
// the next completed frame. There is no back-pressure.
module uart_rx
  import uart_pkg::*;
#(
  parameter int N_DATA_BITS = DEF_N_DATA_BITS,
  parameter int SB_TICK     = DEF_SB_TICK
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx,
  input  logic                   s_tick,
  output logic [N_DATA_BITS-1:0] dout,
  output logic                   rx_done_tick,
  output logic                   frame_error
);

  localparam int NW = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;

  // Tick-counter compare points: middle of the start bit, end of a data bit,
  // end of the stop period.
  localparam logic [3:0]    S_MID  = 4'd7;
  localparam logic [3:0]    S_LAST = 4'd15;
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
  localparam logic [3:0]    S_ONE  = 4'd1;
  localparam logic [NW-1:0] N_LAST = NW'(N_DATA_BITS - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  logic                   rx_s;
  state_t                 state;
  logic [3:0]             s_cnt;
  logic [NW-1:0]          n_cnt;
  logic [N_DATA_BITS-1:0] b_reg;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Receive FSM with its counters, shift register and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        // A low line starts a frame at once; no tick needed to leave IDLE.
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        // Re-check the line in the middle of the start bit to reject glitches.
        START: begin
          if (s_tick) begin
            if (s_cnt == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
        // One sample per bit period, LSB first, shifted in from the top.
        DATA: begin
          if (s_tick) begin
            if (s_cnt == S_LAST) begin
              b_reg <= {rx_s, b_reg[N_DATA_BITS-1:1]};
              s_cnt <= '0;
              if (n_cnt == N_LAST) begin
                state <= STOP;
              end else begin
                n_cnt <= n_cnt + N_ONE;
              end
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
        // Stop bit sampled in its middle; word is published even on error.
        STOP: begin
          if (s_tick) begin
            if (s_cnt == S_STOP) begin
              dout         <= b_reg;
              rx_done_tick <= 1'b1;
              frame_error  <= ~rx_s;
              state        <= IDLE;
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
